// File: rtl/score_pkg.sv
// Shared types and helpers for the score keeper.
// Provides the BCD digit type, blank segment code and 7-seg decode.
package score_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}; codes above 9 render blank.
  function automatic logic [6:0] seg7_decode(input bcd_t b);
    logic [6:0] s;
    case (b)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-seg scanner with optional leading-zero blanking.
// In: clk, rstn, value_i (packed BCD). Out: an_o (active-low), seg_o.
module seg7_scan
  import score_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 17,
  parameter int BLANK_LEAD = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [4*DIGITS-1:0]   value_i,
  output logic [DIGITS-1:0]     an_o,
  output logic [7:0]            seg_o
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SCAN_DIV-1:0] cnt_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   lit;
  logic                nz;
  bcd_t                sel;

  always_comb begin
    idx_d = idx_q;
    if (&cnt_q) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit stays lit if it or any higher digit is non-zero.
  always_comb begin
    nz  = 1'b0;
    lit = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz     = nz | (value_i[4*i +: 4] != 4'd0);
      lit[i] = (BLANK_LEAD == 0) || nz || (i == 0);
    end
  end

  always_comb begin
    sel   = value_i[4*idx_q +: 4];
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = lit[idx_q] ? {1'b1, seg7_decode(sel)} : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an_o  = an_q;
  assign seg_o = seg_q;

endmodule

// File: rtl/score_keeper.sv
// BCD score counter with session high score and 7-seg display drive.
// In: clk, rstn, tick, run, clear, show_hi. Out: score/hi BCD, flags, AN, Segment.
module score_keeper
  import score_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 17,
  parameter int BLANK_LEAD = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                tick,
  input  logic                run,
  input  logic                clear,
  input  logic                show_hi,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] hi_bcd,
  output logic                new_hi,
  output logic                sat,
  output logic [DIGITS-1:0]   AN,
  output logic [7:0]          Segment
);

  localparam logic [4*DIGITS-1:0] ALL9 = {DIGITS{4'h9}};

  logic [4*DIGITS-1:0] score_q, score_d;
  logic [4*DIGITS-1:0] hi_q, hi_d;
  logic [4*DIGITS-1:0] score_inc;
  logic                new_hi_q, new_hi_d;
  logic                sat_w, acc, carry;

  assign sat_w = (score_q == ALL9);
  assign acc   = tick & run & ~sat_w;

  // Ripple BCD increment.
  always_comb begin
    carry     = 1'b1;
    score_inc = score_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Hi tracks score once caught up, so it just takes the same value.
  always_comb begin
    score_d  = score_q;
    hi_d     = hi_q;
    new_hi_d = new_hi_q;
    if (clear) begin
      score_d  = '0;
      new_hi_d = 1'b0;
    end else if (acc) begin
      score_d = score_inc;
      if (score_q == hi_q) begin
        hi_d     = score_inc;
        new_hi_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      score_q  <= '0;
      hi_q     <= '0;
      new_hi_q <= 1'b0;
    end else begin
      score_q  <= score_d;
      hi_q     <= hi_d;
      new_hi_q <= new_hi_d;
    end
  end

  seg7_scan #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_LEAD(BLANK_LEAD)
  ) u_scan (
    .clk    (clk),
    .rstn   (rstn),
    .value_i(show_hi ? hi_q : score_q),
    .an_o   (AN),
    .seg_o  (Segment)
  );

  assign score_bcd = score_q;
  assign hi_bcd    = hi_q;
  assign new_hi    = new_hi_q;
  assign sat       = sat_w;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper (DIGITS=4, SCAN_DIV=2).
// A second instance with BLANK_LEAD=0 shares all inputs.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rstn, tick, run, clear, show_hi;
  logic [15:0] score, hi, score2, hi2;
  logic        new_hi, sat, new_hi2, sat2;
  logic [3:0]  an, an2;
  logic [7:0]  seg, seg2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_keeper #(.DIGITS(4), .SCAN_DIV(2), .BLANK_LEAD(1)) dut (
    .clk(clk), .rstn(rstn), .tick(tick), .run(run),
    .clear(clear), .show_hi(show_hi),
    .score_bcd(score), .hi_bcd(hi), .new_hi(new_hi), .sat(sat),
    .AN(an), .Segment(seg)
  );

  score_keeper #(.DIGITS(4), .SCAN_DIV(2), .BLANK_LEAD(0)) dut2 (
    .clk(clk), .rstn(rstn), .tick(tick), .run(run),
    .clear(clear), .show_hi(show_hi),
    .score_bcd(score2), .hi_bcd(hi2), .new_hi(new_hi2), .sat(sat2),
    .AN(an2), .Segment(seg2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  // Bounded wait for a given anode pattern.
  task automatic wait_an(input logic [3:0] pat, input string tag);
    int n;
    n = 0;
    while (an !== pat && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_an"}, {28'd0, an}, {28'd0, pat});
  endtask

  initial begin
    rstn = 1'b0; tick = 1'b0; run = 1'b0;
    clear = 1'b0; show_hi = 1'b0;
    repeat (3) step();
    chk("rst_an", {28'd0, an}, 32'h0000_000F);
    chk("rst_seg", {24'd0, seg}, 32'h0000_00FF);
    chk("rst_score", {16'd0, score}, 32'h0);
    chk("rst_hi", {16'd0, hi}, 32'h0);
    chk("rst_newhi", {31'd0, new_hi}, 32'h0);
    chk("rst_sat", {31'd0, sat}, 32'h0);

    rstn = 1'b1;
    step();
    chk("rel_an", {28'd0, an}, 32'h0000_000E);
    chk("rel_seg", {24'd0, seg}, 32'h0000_00C0);

    run = 1'b1;
    ticks(10);
    chk("t10_score", {16'd0, score}, 32'h0010);
    chk("t10_hi", {16'd0, hi}, 32'h0010);
    chk("t10_newhi", {31'd0, new_hi}, 32'h1);

    clear = 1'b1; step(); clear = 1'b0;
    ticks(5);
    chk("c5_score", {16'd0, score}, 32'h0005);
    chk("c5_hi", {16'd0, hi}, 32'h0010);
    chk("c5_newhi", {31'd0, new_hi}, 32'h0);
    ticks(6);
    chk("c11_score", {16'd0, score}, 32'h0011);
    chk("c11_hi", {16'd0, hi}, 32'h0011);
    chk("c11_newhi", {31'd0, new_hi}, 32'h1);

    run = 1'b0;
    ticks(3);
    chk("norun_score", {16'd0, score}, 32'h0011);
    run = 1'b1;
    tick = 1'b1; clear = 1'b1; step();
    tick = 1'b0; clear = 1'b0; step();
    chk("tclr_score", {16'd0, score}, 32'h0000);
    chk("tclr_hi", {16'd0, hi}, 32'h0011);

    // Level-sensitive tick: held high counts every cycle.
    tick = 1'b1;
    repeat (9998) step();
    tick = 1'b0;
    step();
    chk("pre_score", {16'd0, score}, 32'h9998);
    chk("pre_sat", {31'd0, sat}, 32'h0);
    ticks(3);
    chk("sat_score", {16'd0, score}, 32'h9999);
    chk("sat_flag", {31'd0, sat}, 32'h1);
    chk("sat_hi", {16'd0, hi}, 32'h9999);

    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_sat", {31'd0, sat}, 32'h0);
    ticks(105);
    chk("s105", {16'd0, score}, 32'h0105);
    chk("s105_hi", {16'd0, hi}, 32'h9999);
    chk("s105_newhi", {31'd0, new_hi}, 32'h0);

    wait_an(4'b1110, "d0");
    chk("d0_seg", {24'd0, seg}, 32'h92);
    chk("d0_seg2", {24'd0, seg2}, 32'h92);
    wait_an(4'b1101, "d1");
    chk("d1_seg", {24'd0, seg}, 32'hC0);
    chk("d1_seg2", {24'd0, seg2}, 32'hC0);
    wait_an(4'b1011, "d2");
    chk("d2_seg", {24'd0, seg}, 32'hF9);
    chk("d2_seg2", {24'd0, seg2}, 32'hF9);
    wait_an(4'b0111, "d3");
    chk("d3_seg", {24'd0, seg}, 32'hFF);
    chk("d3_an2", {28'd0, an2}, 32'h7);
    chk("d3_seg2", {24'd0, seg2}, 32'hC0);

    show_hi = 1'b1;
    step(); step();
    wait_an(4'b1110, "h0");
    chk("h0_seg", {24'd0, seg}, 32'h90);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
